pipeline_hazard_controller: RTL
===============================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001: Parameter DIV_CYCLES, default 32, SHALL be the total stall cycles per long divide/remainder; legal range 2..63.
REQ-002: CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003: Reset  in  1  reset, asynchronous and active-low.
REQ-004: ID_RS1, ID_RS2  in  5 each  source register addresses of the instruction in ID.
REQ-005: ID_Uses_RS1, ID_Uses_RS2  in  1 each  instruction in ID reads that source.
REQ-006: EX_Mem_Read, EX_Write_Enable  in  1 each  ID/EX-stage control outputs of the instruction in EX.
REQ-007: EX_WriteAddress  in  5  destination register of the instruction in EX.
REQ-008: EX_Is_Div  in  1  instruction in EX is DIV/DIVU/REM/REMU.
REQ-009: EX_Branch_Taken  in  1  taken branch or jump resolved in EX.
REQ-010: PC_STALL, IF_ID_STALL  out  1 each  hold PC / IF-ID register.
REQ-011: IF_ID_FLUSH  out  1  clear IF-ID register.
REQ-012: ID_EX_BUBBLE  out  1  drives the ID/EX register BUBBLE input.
REQ-013: EX_HOLD  out  1  ID/EX register retains its contents.
REQ-014: EX_MEM_BUBBLE  out  1  insert a bubble into EX/MEM.
REQ-015: DIV_Start  out  1  one-cycle start pulse to the divider.
REQ-016: Div_Result_Valid  out  1  divider result valid for EX/MEM capture.
REQ-017: Busy  out  1  high in DIV_BUSY.
REQ-018: Stall_Count  out  32  count of cycles with PC_STALL=1.

Function
REQ-019: FSM states SHALL be RUN, DIV_BUSY and DIV_DONE, plus a 6-bit down-counter Div_Cnt.
REQ-020: Load_Use SHALL be EX_Mem_Read & EX_Write_Enable & (EX_WriteAddress!=0) & ((ID_Uses_RS1 & ID_RS1==EX_WriteAddress) | (ID_Uses_RS2 & ID_RS2==EX_WriteAddress)).
REQ-021: In RUN, event priority SHALL be EX_Branch_Taken > EX_Is_Div > Load_Use; lower-priority events in the same cycle are ignored.
REQ-022: RUN with EX_Branch_Taken: IF_ID_FLUSH=1 and ID_EX_BUBBLE=1 combinationally that cycle, no stall; state stays RUN.
REQ-023: RUN with Load_Use: PC_STALL=IF_ID_STALL=ID_EX_BUBBLE=1 for exactly that cycle; state stays RUN.
REQ-024: RUN with EX_Is_Div: DIV_Start=1 and PC_STALL=IF_ID_STALL=EX_HOLD=EX_MEM_BUBBLE=1 that cycle; on the next edge, state becomes DIV_BUSY and Div_Cnt loads DIV_CYCLES-1.
REQ-025: DIV_BUSY: PC_STALL=IF_ID_STALL=EX_HOLD=EX_MEM_BUBBLE=Busy=1, and Div_Cnt decrements each edge; when Div_Cnt==1, the next state is DIV_DONE.
REQ-026: DIV_BUSY SHALL ignore Load_Use, EX_Branch_Taken and EX_Is_Div, and DIV_Start SHALL be 0 throughout.
REQ-027: DIV_DONE: Div_Result_Valid=1 with all stall/hold/bubble outputs 0; the next state is unconditionally RUN, so the divide leaves EX and no restart occurs.
REQ-028: Total stalled cycles per divide SHALL equal DIV_CYCLES; back-to-back divides SHALL restart on the first RUN cycle after DIV_DONE.
REQ-029: All outputs not asserted by REQ-022..027 SHALL be 0.
REQ-030: Stall_Count SHALL increment by 1 on each edge where PC_STALL=1 and wrap from 0xFFFFFFFF to 0.
REQ-031: ID_EX_BUBBLE and EX_HOLD SHALL never be 1 in the same cycle.

Reset
REQ-032: Reset low SHALL immediately force state=RUN, Div_Cnt=0 and Stall_Count=0, and force every output to 0, independent of CLK.
REQ-033: Reset asserted mid-divide SHALL abort the divide; after release, the controller resumes in RUN with no DIV_Start until EX_Is_Div is sampled in RUN.
REQ-034: Release of Reset SHALL take effect at the first posedge CLK after deassertion.

Verification
REQ-035: Load-use: EX_Mem_Read=1, EX_Write_Enable=1, EX_WriteAddress=5, ID_RS2=5, ID_Uses_RS2=1 -> one cycle of PC_STALL/IF_ID_STALL/ID_EX_BUBBLE=1, and Stall_Count goes 0->1.
REQ-036: Load to x0: same as REQ-035 with EX_WriteAddress=0 -> no stall and no bubble.
REQ-037: Divide with DIV_CYCLES=32: EX_Is_Div=1 in RUN -> DIV_Start for 1 cycle, 32 consecutive stall cycles, Div_Result_Valid in cycle 33, Stall_Count=32.
REQ-038: Simultaneous EX_Branch_Taken=1 and Load_Use -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_STALL=0.
REQ-039: Reset low at DIV_BUSY with Div_Cnt=10 -> outputs 0 asynchronously, and after release state is RUN with Busy=0.
REQ-040: Stall_Count preloaded near wrap (0xFFFFFFFE) plus 3 stall cycles -> Stall_Count=1.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use, branch-flush and multi-cycle divide hazard control
module pipeline_hazard_controller #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_Uses_RS1,
    input  logic        ID_Uses_RS2,
    input  logic        EX_Mem_Read,
    input  logic        EX_Write_Enable,
    input  logic [4:0]  EX_WriteAddress,
    input  logic        EX_Is_Div,
    input  logic        EX_Branch_Taken,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_BUBBLE,
    output logic        EX_HOLD,
    output logic        EX_MEM_BUBBLE,
    output logic        DIV_Start,
    output logic        Div_Result_Valid,
    output logic        Busy,
    output logic [31:0] Stall_Count
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    logic [1:0] state;
    logic [5:0] Div_Cnt;
    logic       load_use, in_run, in_busy, take_br, go_div, lu_stall;

    // Hazard decode; every output is gated by Reset so it drops immediately while reset is held
    always_comb begin
        load_use = EX_Mem_Read & EX_Write_Enable & (EX_WriteAddress != 5'd0) &
                   ((ID_Uses_RS1 & (ID_RS1 == EX_WriteAddress)) |
                    (ID_Uses_RS2 & (ID_RS2 == EX_WriteAddress)));
        in_run           = Reset & (state == RUN);
        in_busy          = Reset & (state == DIV_BUSY);
        take_br          = in_run & EX_Branch_Taken;
        go_div           = in_run & ~EX_Branch_Taken & EX_Is_Div;
        lu_stall         = in_run & ~EX_Branch_Taken & ~EX_Is_Div & load_use;
        IF_ID_FLUSH      = take_br;
        ID_EX_BUBBLE     = take_br | lu_stall;
        PC_STALL         = go_div | in_busy | lu_stall;
        IF_ID_STALL      = go_div | in_busy | lu_stall;
        EX_HOLD          = go_div | in_busy;
        EX_MEM_BUBBLE    = go_div | in_busy;
        DIV_Start        = go_div;
        Busy             = in_busy;
        Div_Result_Valid = Reset & (state == DIV_DONE);
    end

    // Divide sequencing: start cycle plus DIV_CYCLES-1 busy cycles, then one result cycle
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= RUN;
            Div_Cnt <= 6'd0;
        end else if (state == RUN) begin
            state   <= go_div ? DIV_BUSY : RUN;
            Div_Cnt <= go_div ? 6'(DIV_CYCLES - 1) : 6'd0;
        end else if (state == DIV_BUSY) begin
            state   <= (Div_Cnt == 6'd1) ? DIV_DONE : DIV_BUSY;
            Div_Cnt <= Div_Cnt - 6'd1;
        end else begin
            state   <= RUN;
            Div_Cnt <= 6'd0;
        end
    end

    // Free-running count of stalled cycles, wrapping naturally at 32 bits
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            Stall_Count <= 32'd0;
        else if (PC_STALL)
            Stall_Count <= Stall_Count + 32'd1;
    end
endmodule
